pim_host_ctrl: RTL and testbench

//  Initiator side of the my_pim port: converts valid/ready commands into my_pim

---
 rtl/pim_host_pkg.sv | 21 ++
 rtl/pim_host_ctrl_if.sv | 35 +++
 rtl/pim_rsp_fifo.sv | 67 ++++++
 rtl/pim_host_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pim_host_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_host_pkg.sv
// Shared types and default widths for the my_pim host controller.
// FSM state encodings stay plain constants so legacy code can compare them directly.
package pim_host_pkg;

    localparam int unsigned ADDR_W_DEF    = 9;
    localparam int unsigned DATA_W_DEF    = 40;
    localparam int unsigned OUT_W_DEF     = 8;
    localparam int unsigned RD_LAT_DEF    = 1;
    localparam int unsigned RSP_DEPTH_DEF = 4;

    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t WR_WAIT = 2'd1;
    localparam state_t BURST   = 2'd2;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [OUT_W_DEF-1:0]  data;
    } rsp_t;

endpackage

// File: rtl/pim_host_ctrl_if.sv
// Command, response and my_pim signal bundle for pim_host_ctrl.
// slave = the controller itself, master = fabric plus PIM macro side.
interface pim_host_ctrl_if
    import pim_host_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [3:0]        cmd_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [OUT_W-1:0]  rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] pim_data;
    logic [ADDR_W-1:0] pim_addr;
    logic              pim_we;
    logic [OUT_W-1:0]  pim_out;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_len, rsp_ready, pim_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, pim_data, pim_addr, pim_we
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data, cmd_len, rsp_ready, pim_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, pim_data, pim_addr, pim_we
    );

endinterface

// File: rtl/pim_rsp_fifo.sv
// Show-ahead synchronous response FIFO; count feeds the controller's credit check.
module pim_rsp_fifo
    import pim_host_pkg::*;
#(
    parameter int unsigned DEPTH = RSP_DEPTH_DEF,
    parameter int unsigned WIDTH = ADDR_W_DEF + OUT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full, do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) assert (!(push && full && !pop));
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/pim_host_ctrl.sv
// my_pim initiator: valid/ready commands to registered pim cycles, read data back via FIFO.
// Optional burst reads are built when PIM_HOST_BURST_EN is defined.
module pim_host_ctrl
    import pim_host_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned OUT_W     = OUT_W_DEF,
    parameter int unsigned RD_LAT    = RD_LAT_DEF,
    parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pim_host_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH) + 1;
    // Stage 0 is the cycle pim_addr is presented; the last stage samples pim_out.
    localparam int unsigned PIPE_N = RD_LAT + 1;
    localparam int unsigned SUM_W  = $clog2(RSP_DEPTH + PIPE_N + 1) + 1;

    state_t              state_q, state_d;
    logic                pim_we_q, pim_we_d;
    logic [ADDR_W-1:0]   pim_addr_q, pim_addr_d;
    logic [DATA_W-1:0]   pim_data_q, pim_data_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [PIPE_N-1:0]   vld_pipe_q, vld_pipe_d;
    logic [ADDR_W-1:0]   addr_pipe_q [PIPE_N];
    logic [ADDR_W-1:0]   addr_pipe_d [PIPE_N];
`ifdef PIM_HOST_BURST_EN
    logic [ADDR_W-1:0]   burst_addr_q, burst_addr_d;
    logic [3:0]          burst_rem_q, burst_rem_d;
`else
    logic                len_unused;
`endif

    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty, fifo_push, fifo_pop;
    logic [ADDR_W+OUT_W-1:0] fifo_wdata, fifo_rdata;
    logic [SUM_W-1:0]        inflight;
    logic                    has_credit, accept, issue_rd;
    logic [ADDR_W-1:0]       issue_addr;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < PIPE_N; i++) inflight = inflight + SUM_W'(vld_pipe_q[i]);
        has_credit = (inflight + SUM_W'(fifo_count)) < SUM_W'(RSP_DEPTH);
    end

    assign bus.cmd_ready = (state_q == IDLE) && has_credit;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d    = state_q;
        pim_we_d   = 1'b0;
        pim_addr_d = pim_addr_q;
        pim_data_d = pim_data_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        issue_rd   = 1'b0;
        issue_addr = pim_addr_q;
`ifdef PIM_HOST_BURST_EN
        burst_addr_d = burst_addr_q;
        burst_rem_d  = burst_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept && bus.cmd_we) begin
                    if (inflight == '0) begin
                        pim_we_d   = 1'b1;
                        pim_addr_d = bus.cmd_addr;
                        pim_data_d = bus.cmd_data;
                    end else begin
                        wr_addr_d = bus.cmd_addr;
                        wr_data_d = bus.cmd_data;
                        state_d   = WR_WAIT;
                    end
                end else if (accept) begin
                    issue_rd   = 1'b1;
                    issue_addr = bus.cmd_addr;
`ifdef PIM_HOST_BURST_EN
                    if (bus.cmd_len != 4'd0) begin
                        burst_addr_d = bus.cmd_addr + ADDR_W'(1);
                        burst_rem_d  = bus.cmd_len;
                        state_d      = BURST;
                    end
`endif
                end
            end
            WR_WAIT: begin
                if (inflight == '0) begin
                    pim_we_d   = 1'b1;
                    pim_addr_d = wr_addr_q;
                    pim_data_d = wr_data_q;
                    state_d    = IDLE;
                end
            end
`ifdef PIM_HOST_BURST_EN
            BURST: begin
                if (has_credit) begin
                    issue_rd     = 1'b1;
                    issue_addr   = burst_addr_q;
                    burst_addr_d = burst_addr_q + ADDR_W'(1);
                    burst_rem_d  = burst_rem_q - 4'd1;
                    if (burst_rem_q == 4'd1) state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (issue_rd) pim_addr_d = issue_addr;
    end

    always_comb begin
        vld_pipe_d     = {vld_pipe_q[PIPE_N-2:0], issue_rd};
        addr_pipe_d[0] = issue_addr;
        for (int unsigned i = 1; i < PIPE_N; i++) addr_pipe_d[i] = addr_pipe_q[i-1];
    end

    assign fifo_push  = vld_pipe_q[PIPE_N-1];
    assign fifo_wdata = {addr_pipe_q[PIPE_N-1], bus.pim_out};
    assign fifo_pop   = !fifo_empty && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pim_we_q   <= 1'b0;
            pim_addr_q <= '0;
            pim_data_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            vld_pipe_q <= '0;
`ifdef PIM_HOST_BURST_EN
            burst_addr_q <= '0;
            burst_rem_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pim_we_q   <= pim_we_d;
            pim_addr_q <= pim_addr_d;
            pim_data_q <= pim_data_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            vld_pipe_q <= vld_pipe_d;
`ifdef PIM_HOST_BURST_EN
            burst_addr_q <= burst_addr_d;
            burst_rem_q  <= burst_rem_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        addr_pipe_q <= addr_pipe_d;
    end

`ifndef PIM_HOST_BURST_EN
    assign len_unused = ^bus.cmd_len;
`endif

    pim_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (ADDR_W + OUT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head_data (fifo_rdata),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rsp_valid                = !fifo_empty;
    assign {bus.rsp_addr, bus.rsp_data} = fifo_rdata;
    assign bus.pim_we                   = pim_we_q;
    assign bus.pim_addr                 = pim_addr_q;
    assign bus.pim_data                 = pim_data_q;

endmodule

// File: tb/tb_pim_host_ctrl.sv
// Directed plus random bench for pim_host_ctrl against a command-order memory model.
// Burst checks are compiled in when PIM_HOST_BURST_EN is defined.
module tb_pim_host_ctrl;
    import pim_host_pkg::*;

    logic clk;
    logic reset;

    pim_host_ctrl_if #(.ADDR_W(9), .DATA_W(40), .OUT_W(8)) bus ();

    pim_host_ctrl #(
        .ADDR_W    (9),
        .DATA_W    (40),
        .OUT_W     (8),
        .RD_LAT    (1),
        .RSP_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned compared;
    int unsigned mismatched;
    logic        accepted;
    logic [7:0]  pim_mem [512];
    logic [7:0]  ref_mem [512];
    rsp_t        exp_q [$];
    logic [48:0] wr_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference semantics: a read sees every write accepted before it, in command order.
    task automatic model_cmd();
        logic [8:0] a;
        int unsigned n;
        if (bus.cmd_we) begin
            ref_mem[bus.cmd_addr] = bus.cmd_data[7:0];
            wr_q.push_back({bus.cmd_addr, bus.cmd_data});
        end else begin
            n = 1;
`ifdef PIM_HOST_BURST_EN
            n = 32'(bus.cmd_len) + 1;
`endif
            for (int unsigned i = 0; i < n; i++) begin
                a = bus.cmd_addr + 9'(i);
                exp_q.push_back('{addr: a, data: ref_mem[a]});
            end
        end
    endtask

    // One clock: observe at negedge, advance the PIM macro model just after posedge.
    task automatic tick();
        logic        s_we;
        logic [8:0]  s_addr;
        logic [39:0] s_data;
        logic [48:0] w;
        rsp_t        e;
        @(negedge clk);
        accepted = 1'b0;
        s_we   = bus.pim_we;
        s_addr = bus.pim_addr;
        s_data = bus.pim_data;
        if (reset) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                accepted = 1'b1;
                model_cmd();
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_addr", 64'(bus.rsp_addr), 64'(e.addr));
                    check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                end
            end
            if (s_we) begin
                check("pim_we_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    w = wr_q.pop_front();
                    check("pim_wr_addr", 64'(s_addr), 64'(w[48:40]));
                    check("pim_wr_data", 64'(s_data), 64'(w[39:0]));
                end
            end
        end
        @(posedge clk);
        #1;
        bus.pim_out = pim_mem[s_addr];
        if (s_we) pim_mem[s_addr] = s_data[7:0];
    endtask

    task automatic send(input logic we, input logic [8:0] a, input logic [39:0] d,
                        input logic [3:0] len, input int unsigned bound, output logic ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_len   = len;
        ok = 1'b0;
        for (int unsigned i = 0; i < bound && !ok; i++) begin
            tick();
            ok = accepted;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int unsigned bound);
        bus.rsp_ready = 1'b1;
        for (int unsigned i = 0; i < bound && (exp_q.size() != 0 || wr_q.size() != 0); i++) tick();
        check("drain_rsp", 64'(exp_q.size()), 64'd0);
        check("drain_wr", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        logic ok;
        compared   = 0;
        mismatched = 0;
        accepted   = 1'b0;
        for (int unsigned i = 0; i < 512; i++) begin
            pim_mem[i] = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;
        bus.rsp_ready = 1'b1;
        bus.pim_out   = '0;
        reset = 1'b0;
        repeat (3) tick();
        check("rst_pim_we", 64'(bus.pim_we), 64'd0);
        check("rst_pim_addr", 64'(bus.pim_addr), 64'd0);
        check("rst_pim_data", 64'(bus.pim_data), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        reset = 1'b1;
        #1;
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Single write: one pim_we cycle, then hold.
        send(1'b1, 9'd5, 40'h12_3456_789A, 4'd0, 4, ok);
        check("t1_accept", 64'(ok), 64'd1);
        check("t1_we", 64'(bus.pim_we), 64'd1);
        check("t1_addr", 64'(bus.pim_addr), 64'd5);
        check("t1_data", 64'(bus.pim_data), 64'h12_3456_789A);
        tick();
        check("t1_we_low", 64'(bus.pim_we), 64'd0);
        check("t1_addr_hold", 64'(bus.pim_addr), 64'd5);

        // Single read latency.
        send(1'b0, 9'd5, 40'd0, 4'd0, 4, ok);
        check("t2_accept", 64'(ok), 64'd1);
        check("t2_addr", 64'(bus.pim_addr), 64'd5);
        check("t2_we", 64'(bus.pim_we), 64'd0);
        check("t2_valid_t1", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("t2_valid_t2", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("t2_valid_t3", 64'(bus.rsp_valid), 64'd1);
        check("t2_rsp_data", 64'(bus.rsp_data), 64'h9A);
        check("t2_rsp_addr", 64'(bus.rsp_addr), 64'd5);
        drain(10);

        // Backpressure: only RSP_DEPTH reads accepted while the consumer stalls.
        bus.rsp_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            send(1'b0, 9'(20 + i), 40'd0, 4'd0, 4, ok);
            check("t3_accept", 64'(ok), 64'd1);
        end
        send(1'b0, 9'd24, 40'd0, 4'd0, 8, ok);
        check("t3_blocked", 64'(ok), 64'd0);
        check("t3_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("t3_held", 64'(exp_q.size()), 64'd4);
        bus.rsp_ready = 1'b1;
        send(1'b0, 9'd24, 40'd0, 4'd0, 12, ok);
        check("t3_accept5", 64'(ok), 64'd1);
        send(1'b0, 9'd25, 40'd0, 4'd0, 12, ok);
        check("t3_accept6", 64'(ok), 64'd1);
        drain(20);

        // Write behind an in-flight read to the same address.
        send(1'b0, 9'd7, 40'd0, 4'd0, 4, ok);
        check("t4_rd_accept", 64'(ok), 64'd1);
        send(1'b1, 9'd7, 40'h00_0000_00C3, 4'd0, 1, ok);
        check("t4_wr_accept", 64'(ok), 64'd1);
        check("t4_wait_ready", 64'(bus.cmd_ready), 64'd0);
        check("t4_wait_we", 64'(bus.pim_we), 64'd0);
        tick();
        check("t4_wait_we2", 64'(bus.pim_we), 64'd0);
        tick();
        check("t4_we", 64'(bus.pim_we), 64'd1);
        check("t4_we_addr", 64'(bus.pim_addr), 64'd7);
        tick();
        check("t4_we_low", 64'(bus.pim_we), 64'd0);
        send(1'b0, 9'd7, 40'd0, 4'd0, 4, ok);
        drain(10);
        check("t4_mem_new", 64'(pim_mem[7]), 64'hC3);

`ifdef PIM_HOST_BURST_EN
        // Burst across the top of the address space.
        send(1'b0, 9'd510, 40'd0, 4'd3, 4, ok);
        check("t5_accept", 64'(ok), 64'd1);
        check("t5_busy", 64'(bus.cmd_ready), 64'd0);
        check("t5_expected", 64'(exp_q.size()), 64'd4);
        drain(20);
`endif

        // Reset with two reads in flight discards them.
        send(1'b0, 9'd30, 40'd0, 4'd0, 4, ok);
        send(1'b0, 9'd31, 40'd0, 4'd0, 4, ok);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        wr_q.delete();
        check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        for (int unsigned i = 0; i < 6; i++) begin
            tick();
            check("t6_no_push", 64'(bus.rsp_valid), 64'd0);
        end

        // Random traffic with collisions on a small address window.
        for (int unsigned c = 0; c < 400; c++) begin
            if (!bus.cmd_valid && $urandom_range(0, 2) != 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_we    = ($urandom_range(0, 2) == 0);
                bus.cmd_addr  = ($urandom_range(0, 7) == 0) ? 9'(508 + $urandom_range(0, 3))
                                                            : 9'($urandom_range(0, 15));
                bus.cmd_data  = {8'($urandom), $urandom};
                bus.cmd_len   = 4'($urandom_range(0, 5));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (accepted) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
